// File: rtl/popcount_window_sum.sv
// popcount_window_sum: registered sliding-window sum of count samples with threshold alarm and sticky peak
module popcount_window_sum #(
  parameter int CNT_W  = 5,
  parameter int WINDOW = 8,
  parameter int SUM_W  = CNT_W + $clog2(WINDOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             cnt_valid,
  input  logic             clear,
  input  logic [SUM_W-1:0] threshold,
  output logic [SUM_W-1:0] sum_out,
  output logic             sum_valid,
  output logic             window_full,
  output logic             over_thresh,
  output logic [SUM_W-1:0] peak_sum
);
  localparam int PW = $clog2(WINDOW);
  localparam int FW = $clog2(WINDOW + 1);
  logic [CNT_W-1:0] mem [WINDOW];
  logic [PW-1:0]    wr_ptr;
  logic [FW-1:0]    fill;
  logic [CNT_W-1:0] oldest;
  logic [SUM_W-1:0] sum_next;
  logic             accept;
  always_comb begin
    window_full = fill == FW'(WINDOW);
    accept      = cnt_valid && !clear;
    oldest      = window_full ? mem[wr_ptr] : '0;
    // modular arithmetic is exact here: the true result always fits SUM_W
    sum_next    = sum_out + SUM_W'(cnt_in) - SUM_W'(oldest);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      for (int i = 0; i < WINDOW; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      fill        <= '0;
      sum_out     <= '0;
      sum_valid   <= 1'b0;
      over_thresh <= 1'b0;
      peak_sum    <= '0;
    end else begin
      sum_valid <= accept;
      if (accept) begin
        mem[wr_ptr] <= cnt_in;
        wr_ptr      <= wr_ptr == PW'(WINDOW - 1) ? '0 : wr_ptr + PW'(1);
        fill        <= window_full ? fill : fill + FW'(1);
        sum_out     <= sum_next;
        over_thresh <= sum_next > threshold;
        peak_sum    <= sum_next > peak_sum ? sum_next : peak_sum;
      end
    end
  end
endmodule

// File: tb/tb_popcount_window_sum.sv
// tb_popcount_window_sum: directed scenario checks for popcount_window_sum (WINDOW=4)
module tb_popcount_window_sum;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] cnt_in;
  logic       cnt_valid;
  logic       clear;
  logic [6:0] threshold;
  logic [6:0] sum_out;
  logic       sum_valid;
  logic       window_full;
  logic       over_thresh;
  logic [6:0] peak_sum;
  logic [16:0] obs, exp;
  int checks = 0;
  int failures = 0;

  popcount_window_sum #(.CNT_W(5), .WINDOW(4), .SUM_W(7)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .clear(clear),
    .threshold(threshold), .sum_out(sum_out), .sum_valid(sum_valid),
    .window_full(window_full), .over_thresh(over_thresh), .peak_sum(peak_sum)
  );

  always #5 clk = ~clk;
  assign obs = {sum_out, sum_valid, window_full, over_thresh, peak_sum};

  task automatic drive(input logic v, input logic [4:0] d, input logic c);
    cnt_valid = v;
    cnt_in = d;
    clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill;
    int s[4] = '{1, 3, 5, 5};
    int e[4] = '{1, 4, 9, 14};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(s[i]), 1'b0);
      exp = {7'(e[i]), 1'b1, i == 3, e[i] > 10, 7'(e[i])};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL fill[%0d] sum/vld/full/ovr/peak got=%h want=%h", i, obs, exp);
      end
    end
  endtask

  task automatic test_steady;
    int s[4] = '{3, 0, 31, 31};
    int e[4] = '{16, 13, 39, 65};
    int p[4] = '{16, 16, 39, 65};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(s[i]), 1'b0);
      exp = {7'(e[i]), 1'b1, 1'b1, 1'b1, 7'(p[i])};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL steady[%0d] sum/vld/full/ovr/peak got=%h want=%h", i, obs, exp);
      end
    end
    drive(1'b0, 5'd0, 1'b0);
    exp = {7'd65, 1'b0, 1'b1, 1'b1, 7'd65};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL steady_idle got=%h want=%h", obs, exp);
    end
  endtask

  task automatic test_clear_collision;
    drive(1'b1, 5'd7, 1'b1);
    exp = '0;
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL clear_collision got=%h want=%h", obs, exp);
    end
    drive(1'b1, 5'd2, 1'b0);
    exp = {7'd2, 1'b1, 1'b0, 1'b0, 7'd2};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL clear_then_sample got=%h want=%h", obs, exp);
    end
  endtask

  task automatic test_gaps;
    int s[5] = '{1, 3, 5, 5, 3};
    int e[5] = '{1, 4, 9, 14, 16};
    drive(1'b0, 5'd0, 1'b1);
    exp = '0;
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL gaps_clear got=%h want=%h", obs, exp);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'(s[i]), 1'b0);
      exp = {7'(e[i]), 1'b1, i >= 3, e[i] > 10, 7'(e[i])};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL gaps_sample[%0d] got=%h want=%h", i, obs, exp);
      end
      for (int g = 0; g < 3; g++) begin
        if (g == 1) threshold = 7'd100;
        drive(1'b0, 5'd0, 1'b0);
        exp = {7'(e[i]), 1'b0, i >= 3, e[i] > 10, 7'(e[i])};
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL gaps_idle[%0d.%0d] got=%h want=%h", i, g, obs, exp);
        end
      end
      threshold = 7'd10;
    end
  endtask

  task automatic test_max;
    int e;
    drive(1'b0, 5'd0, 1'b1);
    exp = '0;
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL max_clear got=%h want=%h", obs, exp);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'd31, 1'b0);
      e = (i < 4 ? i + 1 : 4) * 31;
      exp = {7'(e), 1'b1, i >= 3, 1'b1, 7'(e)};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL max[%0d] got=%h want=%h", i, obs, exp);
      end
    end
  endtask

  task automatic test_reset;
    #2;
    rst = 1'b1;
    cnt_valid = 1'($urandom);
    cnt_in = 5'($urandom);
    clear = 1'($urandom);
    #1;
    exp = '0;
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_async got=%h want=%h", obs, exp);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_held got=%h want=%h", obs, exp);
    end
    rst = 1'b0;
    drive(1'b1, 5'd6, 1'b0);
    exp = {7'd6, 1'b1, 1'b0, 1'b0, 7'd6};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_restart got=%h want=%h", obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cnt_in = '0;
    cnt_valid = 1'b0;
    clear = 1'b0;
    threshold = 7'd10;
    repeat (2) @(posedge clk);
    #1;
    exp = '0;
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_initial got=%h want=%h", obs, exp);
    end
    rst = 1'b0;
    test_fill();
    test_steady();
    test_clear_collision();
    test_gaps();
    test_max();
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
